// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op codes and FSM states.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise function f(x, y, op); NOT and PASS look only at x.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_f
);

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves o_f
    // unassigned and no latch is inferred.
    o_f = '0;
    case (i_op)
      OP_AND:  o_f = i_x & i_y;
      OP_OR:   o_f = i_x | i_y;
      OP_NOT:  o_f = ~i_x;
      OP_NAND: o_f = ~(i_x & i_y);
      OP_NOR:  o_f = ~(i_x | i_y);
      OP_XOR:  o_f = i_x ^ i_y;
      OP_XNOR: o_f = ~(i_x ^ i_y);
      OP_PASS: o_f = i_x;
      default: o_f = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready flow control, one-cycle latency,
// optional multi-beat accumulation and result flags (zero, all-ones, parity).
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_accum;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ones;
  logic             r_parity;
  logic [CNT_W-1:0] r_beats;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_acc;
  logic             w_in_accum;
  logic             w_emit;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_f;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] w_beats_next;

  // A stalled result blocks new beats; ready never depends on in_valid.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  assign w_acc      = (ACC_EN != 0) && acc;
  assign w_in_accum = (r_state == ST_ACCUM);
  assign w_x        = w_in_accum ? r_accum : a;

  // In ACCUM only the closing beat emits; in IDLE everything but an opening
  // multi-beat accumulation emits.
  assign w_emit = w_in_accum ? last : (!w_acc || last);

  assign w_count_inc  = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
  assign w_beats_next = w_in_accum ? w_count_inc : CNT_ONE;

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op(op),
    .i_x (w_x),
    .i_y (b),
    .o_f (w_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_accum     <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_parity    <= 1'b0;
      r_beats     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below reads the
      // pre-edge register values regardless of statement order.
      if (w_accept) begin
        if (w_in_accum) begin
          if (last) begin
            r_state <= ST_IDLE;
            r_accum <= '0;
            r_count <= '0;
          end else begin
            r_accum <= w_f;
            r_count <= w_count_inc;
          end
        end else if (!w_emit) begin
          r_state <= ST_ACCUM;
          r_accum <= w_f;
          r_count <= CNT_ONE;
        end
      end

      // Result and flags only move on an emitting beat, so they hold under stall.
      if (w_accept && w_emit) begin
        r_out_valid <= 1'b1;
        r_result    <= w_f;
        r_zero      <= (w_f == '0);
        r_ones      <= &w_f;
        r_parity    <= ^w_f;
        r_beats     <= w_beats_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ones      = r_ones;
  assign parity    = r_parity;
  assign beats     = r_beats;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: ops, backpressure, model-checked stream,
// accumulation, reset mid-accumulation and beat-counter saturation (CNT_W=2 copy).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] op;
  logic       acc;
  logic       last;
  logic [7:0] a;
  logic [7:0] b;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] result;
  logic       zero;
  logic       ones;
  logic       parity;
  logic [7:0] beats;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_result;
  logic       s_zero;
  logic       s_ones;
  logic       s_parity;
  logic [1:0] s_beats;

  int n_tests = 0;
  int n_fail  = 0;

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc(acc), .last(last), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ones(ones), .parity(parity), .beats(beats)
  );

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .acc(acc), .last(last), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
    .zero(s_zero), .ones(s_ones), .parity(s_parity), .beats(s_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_f(input logic [2:0] m_op, input logic [7:0] x,
                                         input logic [7:0] y);
    case (m_op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~x;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_beat(input logic [2:0] t_op, input logic t_acc, input logic t_last,
                            input logic [7:0] t_a, input logic [7:0] t_b);
    logic accepted;
    op = t_op; acc = t_acc; last = t_last; a = t_a; b = t_b;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #1;
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("beat_accepted", {31'd0, accepted}, 32'd1);
  endtask

  logic [7:0] exp_ops [8];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;
  int         sent;
  int         recv;
  logic       accept_now;

  initial begin
    exp_ops = '{8'h42, 8'hDB, 8'h3C, 8'hBD, 8'h24, 8'h99, 8'h66, 8'hC3};

    // Reset held for 3 cycles while a beat is being offered.
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    op = 3'd1; acc = 1'b0; last = 1'b0; a = 8'hAA; b = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_beats", {24'd0, beats}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // One op per beat, back to back with out_ready high.
    for (int i = 0; i < 8; i++) begin
      drive_beat(3'(i), 1'b0, 1'b0, 8'hC3, 8'h5A);
      check($sformatf("op%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("op%0d_result", i), {24'd0, result}, {24'd0, exp_ops[i]});
      check($sformatf("op%0d_beats", i), {24'd0, beats}, 32'd1);
      if (i == 0) check("and_parity", {31'd0, parity}, 32'd0);
      if (i == 2) begin
        check("not_parity", {31'd0, parity}, 32'd0);
        check("not_zero", {31'd0, zero}, 32'd0);
      end
    end
    @(posedge clk); #1;
    check("ops_drained", {31'd0, out_valid}, 32'd0);

    // All-ones result: NOR of zeros.
    drive_beat(3'd4, 1'b0, 1'b0, 8'h00, 8'h00);
    check("nor_result", {24'd0, result}, 32'hFF);
    check("nor_ones", {31'd0, ones}, 32'd1);
    check("nor_zero", {31'd0, zero}, 32'd0);
    check("nor_parity", {31'd0, parity}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: result frozen and in_ready low while the consumer stalls.
    out_ready = 1'b0;
    drive_beat(3'd0, 1'b0, 1'b0, 8'hFF, 8'h0F);
    op = 3'd1; acc = 1'b0; last = 1'b0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {24'd0, result}, 32'h0F);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_result", {24'd0, result}, 32'h33);
    check("bp_next_beats", {24'd0, beats}, 32'd1);
    @(posedge clk); #1;
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // 20-beat stream with random ops/operands and random consumer stalls.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 1000 && recv < 20; cyc++) begin
      if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(0, 7));
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        acc = 1'b0; last = 1'b0;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      accept_now = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_out", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("stream_result", {24'd0, result}, {24'd0, exp_v});
          check("stream_beats", {24'd0, beats}, 32'd1);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_f(op, a, b));
        sent++;
        accept_now = 1'b1;
      end
      @(posedge clk); #1;
      if (accept_now) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_recv_count", recv, 32'd20);
    check("stream_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // XOR accumulation over three beats: one output.
    drive_beat(3'd5, 1'b1, 1'b0, 8'h0F, 8'hF0);
    check("accx_b1_quiet", {31'd0, out_valid}, 32'd0);
    drive_beat(3'd5, 1'b1, 1'b0, 8'h00, 8'h33);
    check("accx_b2_quiet", {31'd0, out_valid}, 32'd0);
    drive_beat(3'd5, 1'b1, 1'b1, 8'h00, 8'h55);
    check("accx_valid", {31'd0, out_valid}, 32'd1);
    check("accx_result", {24'd0, result}, 32'h99);
    check("accx_beats", {24'd0, beats}, 32'd3);
    check("accx_parity", {31'd0, parity}, 32'd0);
    check("accx_zero", {31'd0, zero}, 32'd0);
    @(posedge clk); #1;
    check("accx_single_pulse", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of an accumulation discards it.
    drive_beat(3'd1, 1'b1, 1'b0, 8'h0F, 8'hF0);
    drive_beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h01);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    drive_beat(3'd0, 1'b0, 1'b0, 8'hFF, 8'h00);
    check("midrst_valid", {31'd0, out_valid}, 32'd1);
    check("midrst_result", {24'd0, result}, 32'h00);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_beats", {24'd0, beats}, 32'd1);
    @(posedge clk); #1;
    check("midrst_single", {31'd0, out_valid}, 32'd0);

    // OR accumulation of five beats; CNT_W=2 copy saturates at 3.
    drive_beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h01);
    drive_beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h02);
    drive_beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h04);
    drive_beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h08);
    check("sat_quiet", {31'd0, out_valid}, 32'd0);
    drive_beat(3'd1, 1'b1, 1'b1, 8'h00, 8'h10);
    check("sat_valid", {31'd0, s_out_valid}, 32'd1);
    check("sat_result", {24'd0, s_result}, 32'h1F);
    check("sat_beats", {30'd0, s_beats}, 32'd3);
    check("wide_result", {24'd0, result}, 32'h1F);
    check("wide_beats", {24'd0, beats}, 32'd5);
    @(posedge clk); #1;
    check("sat_drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
